// File: rtl/matrix_reader_if.sv
// Stream-in / matrix-write bundle for matrix_reader.
// The slave side is the loader; the master side is the source and store.
interface matrix_reader_if #(parameter int n = 8);
    localparam int n_len = $clog2(n);

    logic              start;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       value;
    logic [n_len:0]    i;
    logic [n_len:0]    j;
    logic              we;
    logic              done;

    modport slave  (input  start, in_data, in_valid,
                    output in_ready, value, i, j, we, done);
    modport master (output start, in_data, in_valid,
                    input  in_ready, value, i, j, we, done);
endinterface

// File: rtl/matrix_reader.sv
// Streaming n x n matrix loader: valid/ready words in, (value,i,j,we) writes out.
// MATRIX_READER_TRANSPOSE_EN: treat the stream as column-major (loads the transpose).
module matrix_reader #(
    parameter int n = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    matrix_reader_if.slave   bus
);
    localparam int n_len = $clog2(n);
    localparam int W     = n_len + 1;
    localparam logic [W-1:0] LAST = W'(n - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   row_q, row_d;
    logic [W-1:0]   col_q, col_d;
    logic [31:0]    value_q, value_d;
    logic [W-1:0]   i_q, i_d;
    logic [W-1:0]   j_q, j_d;
    logic           we_q, we_d;
    logic           done_q, done_d;
    logic           accept;

    assign accept = bus.in_valid && (state_q == LOAD);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        value_d = value_q;
        i_d     = i_q;
        j_d     = j_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    value_d = bus.in_data;
`ifdef MATRIX_READER_TRANSPOSE_EN
                    i_d     = col_q;
                    j_d     = row_q;
`else
                    i_d     = row_q;
                    j_d     = col_q;
`endif
                    we_d    = 1'b1;
                    if (col_q == LAST) begin
                        col_d = '0;
                        // Last element: park counters at 0 so they never pass n-1.
                        if (row_q == LAST) begin
                            row_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            value_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            value_q <= value_d;
            i_q     <= i_d;
            j_q     <= j_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.value    = value_q;
    assign bus.i        = i_q;
    assign bus.j        = j_q;
    assign bus.we       = we_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_matrix_reader.sv
// Bench for matrix_reader: three instances (n=8,4,1) muxed onto one driver,
// checked every cycle against an element-count reference model.
module tb_matrix_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    matrix_reader_if #(.n(8)) if8();
    matrix_reader_if #(.n(4)) if4();
    matrix_reader_if #(.n(1)) if1();

    matrix_reader #(.n(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    matrix_reader #(.n(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    matrix_reader #(.n(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if8.start = start && (sel == 0);
    assign if4.start = start && (sel == 1);
    assign if1.start = start && (sel == 2);
    assign if8.in_valid = valid && (sel == 0);
    assign if4.in_valid = valid && (sel == 1);
    assign if1.in_valid = valid && (sel == 2);
    assign if8.in_data = data;
    assign if4.in_data = data;
    assign if1.in_data = data;

    logic        o_we, o_done, o_ready;
    logic [31:0] o_value;
    logic [3:0]  o_i, o_j;

    always_comb begin
        o_we = 1'b0; o_done = 1'b0; o_ready = 1'b0; o_value = '0; o_i = '0; o_j = '0;
        case (sel)
            0: begin o_we = if8.we; o_done = if8.done; o_ready = if8.in_ready;
                     o_value = if8.value; o_i = 4'(if8.i); o_j = 4'(if8.j); end
            1: begin o_we = if4.we; o_done = if4.done; o_ready = if4.in_ready;
                     o_value = if4.value; o_i = 4'(if4.i); o_j = 4'(if4.j); end
            default: begin o_we = if1.we; o_done = if1.done; o_ready = if1.in_ready;
                     o_value = if1.value; o_i = 4'(if1.i); o_j = 4'(if1.j); end
        endcase
    end

    int n_vec = 0;
    int miscompares = 0;

    // Reference model: a load is just "k elements accepted so far".
    int          m_n = 8;
    int          m_k = 0;
    bit          m_busy = 0;
    logic        e_we, e_done, e_ready;
    logic [31:0] e_value;
    logic [3:0]  e_i, e_j;

    task automatic use_dut(input int s);
        sel = s;
        m_n = (s == 0) ? 8 : (s == 1) ? 4 : 1;
        m_k = 0;
        m_busy = 0;
    endtask

    task automatic model(input logic st, input logic v, input logic [31:0] d);
        int r, c;
        e_we = 1'b0; e_done = 1'b0;
        if (m_busy && v) begin
            r = m_k / m_n;
            c = m_k % m_n;
            e_we = 1'b1;
            e_value = d;
`ifdef MATRIX_READER_TRANSPOSE_EN
            e_i = 4'(c); e_j = 4'(r);
`else
            e_i = 4'(r); e_j = 4'(c);
`endif
            m_k++;
            if (m_k == m_n * m_n) begin
                e_done = 1'b1;
                m_busy = 0;
            end
        end else if (!m_busy && st) begin
            m_busy = 1;
            m_k = 0;
        end
        e_ready = m_busy;
    endtask

    task automatic cyc(input logic st, input logic v, input logic [31:0] d);
        start = st; valid = v; data = d;
        model(st, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_vec++;
            if ({o_we, o_done, o_ready, o_value, o_i, o_j} !== '0) begin
                miscompares++;
                $display("FAIL reset[%0d]: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want all 0",
                         s, o_we, o_done, o_ready, o_value, o_i, o_j);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_row_major;
        logic [31:0] store [8][8];
        logic [31:0] want;
        int wes = 0;
        use_dut(0);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) store[r][c] = '0;
        for (int k = -1; k < 65; k++) begin
            if (k < 0)       cyc(1'b1, 1'b0, 32'h0);
            else if (k < 64) cyc(1'b0, 1'b1, 32'(k + 1));
            else             cyc(1'b0, 1'b0, 32'h0);
            n_vec++;
            if ({o_we, o_done, o_ready} !== {e_we, e_done, e_ready} ||
                (e_we && {o_value, o_i, o_j} !== {e_value, e_i, e_j})) begin
                miscompares++;
                $display("FAIL row_major k=%0d: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want %b%b%b %h %0d %0d",
                         k, o_we, o_done, o_ready, o_value, o_i, o_j,
                         e_we, e_done, e_ready, e_value, e_i, e_j);
            end
            if (o_we) begin
                wes++;
                if (o_i < 8 && o_j < 8) store[o_i[2:0]][o_j[2:0]] = o_value;
            end
        end
        n_vec++;
        if (wes != 64) begin
            miscompares++;
            $display("FAIL row_major we count: got %0d want 64", wes);
        end
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
`ifdef MATRIX_READER_TRANSPOSE_EN
            want = 32'(8 * c + r + 1);
`else
            want = 32'(8 * r + c + 1);
`endif
            n_vec++;
            if (store[r][c] !== want) begin
                miscompares++;
                $display("FAIL store(%0d,%0d): got %0d want %0d", r, c, store[r][c], want);
            end
        end
    endtask

    task automatic test_stalled;
        int wes = 0, dones = 0, cycles = 0;
        use_dut(1);
        cyc(1'b1, 1'b0, 32'h0);
        while (m_busy && cycles < 40) begin
            cyc(1'b0, cycles[0] == 1'b0, $urandom);
            cycles++;
            n_vec++;
            if ({o_we, o_done, o_ready} !== {e_we, e_done, e_ready} ||
                (e_we && {o_value, o_i, o_j} !== {e_value, e_i, e_j})) begin
                miscompares++;
                $display("FAIL stalled cyc=%0d: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want %b%b%b %h %0d %0d",
                         cycles, o_we, o_done, o_ready, o_value, o_i, o_j,
                         e_we, e_done, e_ready, e_value, e_i, e_j);
            end
            wes += int'(o_we);
            dones += int'(o_done);
        end
        n_vec++;
        if (m_busy || wes != 16 || dones != 1) begin
            miscompares++;
            $display("FAIL stalled totals: we=%0d done=%0d busy=%0d, want 16 1 0", wes, dones, m_busy);
        end
    endtask

    task automatic test_start_busy;
        int cycles = 0;
        use_dut(1);
        cyc(1'b1, 1'b1, 32'hAAAA_0000);
        while ((m_busy || cycles == 0) && cycles < 40) begin
            // start again right after the 5th accept, alongside the 6th word
            cyc(m_k == 5 || cycles == 2, 1'b1, 32'hB000_0000 + 32'(cycles));
            cycles++;
            n_vec++;
            if ({o_we, o_done, o_ready} !== {e_we, e_done, e_ready} ||
                (e_we && {o_value, o_i, o_j} !== {e_value, e_i, e_j})) begin
                miscompares++;
                $display("FAIL start_busy cyc=%0d: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want %b%b%b %h %0d %0d",
                         cycles, o_we, o_done, o_ready, o_value, o_i, o_j,
                         e_we, e_done, e_ready, e_value, e_i, e_j);
            end
        end
        n_vec++;
        if (m_busy) begin
            miscompares++;
            $display("FAIL start_busy timeout: load still open after %0d cycles", cycles);
        end
    endtask

    task automatic test_reset_mid_load;
        use_dut(0);
        cyc(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, $urandom);
        rst_n = 1'b0;
        m_busy = 0; m_k = 0;
        #1;
        n_vec++;
        if ({o_we, o_done, o_ready, o_value, o_i, o_j} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want all 0",
                     o_we, o_done, o_ready, o_value, o_i, o_j);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 68; k++) begin
            if (k < 3)       cyc(1'b0, 1'b1, 32'h5555);
            else if (k == 3) cyc(1'b1, 1'b0, 32'h0);
            else             cyc(1'b0, 1'b1, $urandom);
            n_vec++;
            if ({o_we, o_done, o_ready} !== {e_we, e_done, e_ready} ||
                (e_we && {o_value, o_i, o_j} !== {e_value, e_i, e_j})) begin
                miscompares++;
                $display("FAIL after_reset k=%0d: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want %b%b%b %h %0d %0d",
                         k, o_we, o_done, o_ready, o_value, o_i, o_j,
                         e_we, e_done, e_ready, e_value, e_i, e_j);
            end
        end
    endtask

    task automatic test_n1;
        use_dut(2);
        for (int k = 0; k < 3; k++) begin
            cyc(k == 0, k == 1, 32'hDEAD_BEEF);
            n_vec++;
            if ({o_we, o_done, o_ready} !== {e_we, e_done, e_ready} ||
                (e_we && {o_value, o_i, o_j} !== {e_value, e_i, e_j})) begin
                miscompares++;
                $display("FAIL n1 k=%0d: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want %b%b%b %h %0d %0d",
                         k, o_we, o_done, o_ready, o_value, o_i, o_j,
                         e_we, e_done, e_ready, e_value, e_i, e_j);
            end
        end
    endtask

    task automatic test_random;
        int cycles;
        use_dut(1);
        for (int load = 0; load < 4; load++) begin
            cycles = 0;
            while ((!m_busy && cycles < 5) || (m_busy && cycles < 200)) begin
                cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom);
                cycles++;
                n_vec++;
                if ({o_we, o_done, o_ready} !== {e_we, e_done, e_ready} ||
                    (e_we && {o_value, o_i, o_j} !== {e_value, e_i, e_j})) begin
                    miscompares++;
                    $display("FAIL random load=%0d cyc=%0d: we/done/rdy=%b%b%b val=%h i=%0d j=%0d, want %b%b%b %h %0d %0d",
                             load, cycles, o_we, o_done, o_ready, o_value, o_i, o_j,
                             e_we, e_done, e_ready, e_value, e_i, e_j);
                end
                if (e_done) break;
            end
        end
        cyc(1'b0, 1'b0, 32'h0);
        if (m_busy) begin
            for (int k = 0; k < 20 && m_busy; k++) cyc(1'b0, 1'b1, $urandom);
        end
    endtask

    initial begin
        test_reset;
        test_row_major;
        test_stalled;
        test_start_busy;
        test_reset_mid_load;
        test_n1;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule
